// File: rtl/regfile_sb_pkg.sv
// Shared constants for the scoreboarded register file.
package regfile_sb_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int NREGS_DEF  = 32;
    localparam int NRD_DEF    = 2;

    // Architectural register that is hardwired to zero and never pending.
    localparam int ZERO_REG   = 0;

endpackage : regfile_sb_pkg

// File: rtl/regfile_scoreboard.sv
// Pending-bit scoreboard: tracks registers with an issued but not yet
// written-back result, keeps a registered count of them, and flags
// reserves that hit an already-pending register.
module regfile_scoreboard
    import regfile_sb_pkg::*;
#(
    parameter  int NREGS  = NREGS_DEF,
    localparam int ADDR_W = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic [NREGS-1:0]  pending,
    output logic [ADDR_W:0]   pend_cnt,
    output logic              rsv_err
);

    logic              wr_hit;
    logic              rsv_hit;
    logic [NREGS-1:0]  pending_next;
    logic [ADDR_W:0]   cnt_next;

    assign wr_hit  = wr_en  && (wr_addr  != ADDR_W'(ZERO_REG));
    assign rsv_hit = rsv_en && (rsv_addr != ADDR_W'(ZERO_REG));

    // Next pending vector: write-back clears first, then reserve sets, so a
    // same-cycle reserve and write to one register leaves it pending.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        pending_next = pending;
        if (wr_hit) begin
            pending_next[wr_addr] = 1'b0;
        end
        if (rsv_hit) begin
            pending_next[rsv_addr] = 1'b1;
        end
        pending_next[ZERO_REG] = 1'b0;
    end

    // Population count of the next pending vector, so the registered count
    // lands on the same edge as the pending bits it describes.
    always_comb begin
        cnt_next = '0;
        for (int i = 0; i < NREGS; i++) begin
            // NOTE: blocking assignments here accumulate within the loop;
            // clocked state below uses non-blocking assignments only.
            cnt_next = cnt_next + (ADDR_W+1)'(pending_next[i]);
        end
    end

    // Pending bits and count register, cleared asynchronously on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending  <= '0;
            pend_cnt <= '0;
        end else begin
            pending  <= pending_next;
            pend_cnt <= cnt_next;
        end
    end

    // Reserve of a register that is still pending, unless the same cycle's
    // write-back retires the earlier producer.
    always_comb begin
        rsv_err = rst_n && rsv_hit && pending[rsv_addr]
                  && !(wr_hit && (wr_addr == rsv_addr));
    end

endmodule : regfile_scoreboard

// File: rtl/regfile_sb.sv
// Register file with write-back source mux, same-cycle write bypass on
// every read port, and a pending-bit scoreboard that produces issue stall.
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter  int DATA_W = DATA_W_DEF,
    parameter  int NREGS  = NREGS_DEF,
    parameter  int NRD    = NRD_DEF,
    localparam int ADDR_W = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic                  wb_sel,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [DATA_W-1:0]     wr_result,
    input  logic                  rsv_en,
    input  logic [ADDR_W-1:0]     rsv_addr,
    input  logic [NRD*ADDR_W-1:0] rd_addr,
    input  logic [NRD-1:0]        rd_use,
    output logic [NRD*DATA_W-1:0] rd_data,
    output logic [NRD-1:0]        rd_busy,
    output logic                  stall,
    output logic                  rsv_err,
    output logic [ADDR_W:0]       pend_cnt
);

    logic [DATA_W-1:0] regs [NREGS];
    logic [NREGS-1:0]  pending;
    logic              wr_hit;
    logic [DATA_W-1:0] wr_val;

    // Write-back value and qualified write strobe (register 0 is never written).
    always_comb begin
        wr_val = wb_sel ? wr_result : wr_data;
        wr_hit = wr_en && (wr_addr != ADDR_W'(ZERO_REG));
    end

    // Architectural storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the whole array is cleared on reset because software may
            // read registers before writing them; this rules out RAM macros.
            for (int r = 0; r < NREGS; r++) begin
                regs[r] <= '0;
            end
        end else if (wr_hit) begin
            regs[wr_addr] <= wr_val;
        end
    end

    regfile_scoreboard #(
        .NREGS (NREGS)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .pending  (pending),
        .pend_cnt (pend_cnt),
        .rsv_err  (rsv_err)
    );

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic              byp;

        assign addr = rd_addr[i*ADDR_W +: ADDR_W];
        assign byp  = wr_hit && (wr_addr == addr);

        // Read port: zero register and reset force 0; a same-cycle write to
        // the addressed register is forwarded and also clears busy.
        always_comb begin
            rd_data[i*DATA_W +: DATA_W] = '0;
            rd_busy[i]                  = 1'b0;
            if (rst_n && (addr != ADDR_W'(ZERO_REG))) begin
                rd_data[i*DATA_W +: DATA_W] = byp ? wr_val : regs[addr];
                rd_busy[i]                  = pending[addr] && !byp;
            end
        end
    end

    // Issue must hold while any consumed operand is still in flight.
    always_comb begin
        stall = |(rd_use & rd_busy);
    end

endmodule : regfile_sb

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter DATA_W, default 32, register data width in bits.
REQ-002 Parameter NREGS, default 32, number of architectural registers (power of two, >=2); ADDR_W = clog2(NREGS).
REQ-003 Parameter NRD, default 2, number of read ports.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 wr_en  in  1  write-back enable.
REQ-007 wr_addr  in  ADDR_W  write-back destination.
REQ-008 wb_sel  in  1  write source select: 1 = wr_result, 0 = wr_data.
REQ-009 wr_data  in  DATA_W  memory-stage write data.
REQ-010 wr_result  in  DATA_W  ALU-result write data.
REQ-011 rsv_en  in  1  reserve destination at issue (mark pending).
REQ-012 rsv_addr  in  ADDR_W  register to reserve.
REQ-013 rd_addr  in  NRD*ADDR_W  packed read addresses, port i at bits [i*ADDR_W +: ADDR_W].
REQ-014 rd_use  in  NRD  port i operand is actually consumed this cycle.
REQ-015 rd_data  out  NRD*DATA_W  packed read data, same packing as rd_addr.
REQ-016 rd_busy  out  NRD  port i operand not yet available.
REQ-017 stall  out  1  issue must hold.
REQ-018 rsv_err  out  1  reserve targets an already-pending register.
REQ-019 pend_cnt  out  ADDR_W+1  registered count of pending registers.

Function
REQ-020 Register 0 SHALL read as 0 on every port, ignore writes, and never be pending.
REQ-021 Write: on rising edge with wr_en=1 and wr_addr!=0, reg[wr_addr] <= (wb_sel ? wr_result : wr_data).
REQ-022 Reads SHALL be combinational, zero-cycle latency.
REQ-023 Bypass: if wr_en=1, wr_addr!=0 and wr_addr==rd_addr[i], rd_data[i] SHALL equal the selected write value in that same cycle.
REQ-024 Scoreboard: one pending bit per register; rsv_en=1, rsv_addr!=0 sets pending[rsv_addr] next edge; wr_en=1, wr_addr!=0 clears pending[wr_addr] next edge.
REQ-025 Simultaneous reserve and write to the same address: set wins (pending stays 1).
REQ-026 rd_busy[i] = pending[rd_addr[i]] AND NOT (bypass hit on port i); rd_busy[i]=0 for address 0.
REQ-027 stall = OR over i of (rd_use[i] AND rd_busy[i]); combinational.
REQ-028 rsv_err = rsv_en AND rsv_addr!=0 AND pending[rsv_addr] AND NOT (write to rsv_addr this cycle); combinational; the reserve still takes effect.
REQ-029 pend_cnt SHALL update one cycle after pending changes, equal to popcount(pending), range 0..NREGS-1.
REQ-030 Write to a non-pending register SHALL be legal and leave pending clear.

Reset
REQ-031 rst_n=0 SHALL asynchronously clear all registers, all pending bits and pend_cnt to 0.
REQ-032 During reset, rd_data=0, rd_busy=0, stall=0, rsv_err=0; writes and reserves ignored.
REQ-033 Reset asserted mid-operation discards all pending state; first edge after release behaves as from cold start.

Structure
REQ-034 Shared package SHALL hold default DATA_W, NREGS and the zero-register index constant.
REQ-035 One sub-module regfile_scoreboard (pending bits, pend_cnt, rsv_err) is natural; storage, write mux and bypass stay at top.

Verification
REQ-036 Reset, write r5=0x1234_5678 (wb_sel=0), next cycle read r5 on both ports -> 0x1234_5678; write r0=0xFFFF_FFFF -> r0 reads 0.
REQ-037 Same cycle wr_en, wr_addr=7, wb_sel=1, wr_result=0xA5A5_A5A5, rd_addr[0]=7 -> rd_data[0]=0xA5A5_A5A5 before the edge.
REQ-038 Reserve r3; next cycle rd_addr[1]=3, rd_use[1]=1 -> rd_busy[1]=1, stall=1, pend_cnt=1; write r3 -> bypass, stall=0; after the edge pend_cnt=0.
REQ-039 Reserve r9 while r9 pending -> rsv_err=1; reserve and write r9 same cycle -> pending stays 1, rsv_err=0.
REQ-040 Reserve r1..r4 over four cycles, assert rst_n=0 mid-sequence -> pend_cnt=0, all reads 0 immediately, stall=0.
